// File: rtl/axis_linear_interpolator.sv
// AXIS upsampler: each accepted sample expands into 2**RATIO_POWER beats that
// ramp linearly from the previous sample to the current one.
module axis_linear_interpolator #(
    parameter int BUS_WIDTH   = 1,
    parameter int RATIO_POWER = 2
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic [8*BUS_WIDTH-1:0]   s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [8*BUS_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);
    // state | meaning
    // IDLE  | waiting for an input sample; s_axis_tready high once out of reset
    // RUN   | emitting beats k = 1..R of the current sample

    localparam int W  = 8 * BUS_WIDTH;
    localparam int AW = W + RATIO_POWER + 2;
    localparam int KW = RATIO_POWER + 1;
    localparam logic [KW-1:0] K_LAST = KW'(2 ** RATIO_POWER);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic                 started;
    logic [W-1:0]         prev, cur;
    logic                 last_r;
    logic signed [W:0]    step;
    logic signed [W:0]    step_nxt;
    logic signed [AW-1:0] acc;
    logic [AW-1:0]        prev_scaled;
    logic [KW-1:0]        k;
    logic                 k_last, in_hs, out_hs;

    assign k_last      = (k == K_LAST);
    assign in_hs       = s_axis_tvalid & s_axis_tready;
    assign out_hs      = m_axis_tvalid & m_axis_tready;
    assign step_nxt    = $signed({1'b0, s_axis_tdata}) - $signed({1'b0, prev});
    assign prev_scaled = AW'(prev) << RATIO_POWER;

    always_ff @(posedge aclk) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ready is gated by started so it stays low until the first edge after reset.
    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = started;
                if (s_axis_tvalid && started) state_nxt = RUN;
            end
            RUN: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready && k_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            started <= 1'b0;
            prev    <= '0;
            cur     <= '0;
            last_r  <= 1'b0;
            step    <= '0;
            acc     <= '0;
            k       <= '0;
        end else begin
            started <= 1'b1;
            if (in_hs) begin
                cur    <= s_axis_tdata;
                last_r <= s_axis_tlast;
                step   <= step_nxt;
                acc    <= $signed(prev_scaled)
                          + $signed({{(RATIO_POWER + 1){step_nxt[W]}}, step_nxt});
                k      <= KW'(1);
            end else if (out_hs) begin
                if (k_last) begin
                    prev <= cur;
                end else begin
                    acc <= acc + $signed({{(RATIO_POWER + 1){step[W]}}, step});
                    k   <= k + KW'(1);
                end
            end
        end
    end

    // acc is never negative here, so the shifted slice is the floored beat value.
    assign m_axis_tdata = acc[RATIO_POWER +: W];
    assign m_axis_tlast = last_r & k_last & (state == RUN);

endmodule

// File: tb/tb_axis_linear_interpolator.sv
// Directed bench for axis_linear_interpolator: R=4 byte instance plus an R=1
// 16-bit instance, with hand-computed beat values.
module tb_axis_linear_interpolator;

    logic        aclk = 1'b0;
    logic        arstn;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;

    logic [15:0] s_tdata0;
    logic        s_tvalid0, s_tlast0, s_tready0;
    logic [15:0] m_tdata0;
    logic        m_tvalid0, m_tlast0, m_tready0;

    int n_cmp = 0;
    int n_bad = 0;
    bit stall_mode = 0;

    always #5 aclk = ~aclk;

    axis_linear_interpolator #(.BUS_WIDTH(1), .RATIO_POWER(2)) dut (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready)
    );

    axis_linear_interpolator #(.BUS_WIDTH(2), .RATIO_POWER(0)) dut0 (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tdata(s_tdata0), .s_axis_tvalid(s_tvalid0), .s_axis_tlast(s_tlast0),
        .s_axis_tready(s_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0),
        .m_axis_tready(m_tready0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        arstn    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        @(negedge aclk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata",  32'(m_tdata),  32'd0);
        check("rst_m_tlast",  32'(m_tlast),  32'd0);
        check("rst0_tvalid",  32'(m_tvalid0), 32'd0);
        @(posedge aclk);
        #1;
        arstn = 1'b1;
        @(posedge aclk);
        #1;
        check("rst_rel_tready", 32'(s_tready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bit ok = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge aclk);
            if (s_tready) ok = 1;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("in_hs", 32'(ok), 32'd1);
        check("first_beat_lat", 32'(m_tvalid), 32'd1);
    endtask

    task automatic get_beat(input logic [7:0] exp, input logic exp_last, input string tag);
        bit got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge aclk);
            if (m_tvalid) begin
                check({tag, "_busy"}, 32'(s_tready), 32'd0);
                if (m_tready) begin
                    check(tag, 32'(m_tdata), 32'(exp));
                    check({tag, "_last"}, 32'(m_tlast), 32'(exp_last));
                    got = 1;
                end else begin
                    check({tag, "_hold"}, 32'(m_tdata), 32'(exp));
                end
            end
            @(posedge aclk);
            #1;
            if (stall_mode) begin
                m_tready = 1'($urandom_range(0, 1));
                s_tvalid = !got;
                s_tdata  = 8'hAA;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic get4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic last, input string tag);
        get_beat(a, 1'b0, {tag, "_b1"});
        get_beat(b, 1'b0, {tag, "_b2"});
        get_beat(c, 1'b0, {tag, "_b3"});
        get_beat(d, last, {tag, "_b4"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v0 [3];
        v0[0] = 16'h1234;
        v0[1] = 16'hFFFF;
        v0[2] = 16'h0000;

        arstn = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        s_tdata0 = '0; s_tvalid0 = 1'b0; s_tlast0 = 1'b0; m_tready0 = 1'b1;

        do_reset();
        send(8'd100, 1'b0);
        get4(8'd25, 8'd50, 8'd75, 8'd100, 1'b0, "up100");
        check("ready_after_100", 32'(s_tready), 32'd1);
        send(8'd60, 1'b0);
        get4(8'd90, 8'd80, 8'd70, 8'd60, 1'b0, "down60");
        send(8'd60, 1'b1);
        get4(8'd60, 8'd60, 8'd60, 8'd60, 1'b1, "flat60");

        do_reset();
        send(8'd255, 1'b0);
        get4(8'd63, 8'd127, 8'd191, 8'd255, 1'b0, "fs_up");
        send(8'd0, 1'b0);
        get4(8'd191, 8'd127, 8'd63, 8'd0, 1'b0, "fs_down");

        // random output stalls with junk input offered during RUN
        do_reset();
        stall_mode = 1;
        m_tready   = 1'b0;
        send(8'd100, 1'b0);
        get4(8'd25, 8'd50, 8'd75, 8'd100, 1'b0, "bp_up");
        send(8'd60, 1'b1);
        get4(8'd90, 8'd80, 8'd70, 8'd60, 1'b1, "bp_down");
        stall_mode = 0;
        m_tready   = 1'b1;
        s_tvalid   = 1'b0;

        do_reset();
        send(8'd200, 1'b0);
        get_beat(8'd50, 1'b0, "mid_b1");
        get_beat(8'd100, 1'b0, "mid_b2");
        do_reset();
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        send(8'd40, 1'b0);
        get4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, "after_rst");

        for (int i = 0; i < 3; i++) begin
            s_tvalid0 = 1'b1;
            s_tdata0  = v0[i];
            s_tlast0  = (i == 2);
            @(negedge aclk);
            check("p0_ready", 32'(s_tready0), 32'd1);
            @(posedge aclk);
            #1;
            @(negedge aclk);
            check("p0_valid", 32'(m_tvalid0), 32'd1);
            check("p0_data",  32'(m_tdata0),  32'(v0[i]));
            check("p0_last",  32'(m_tlast0),  32'(i == 2));
            check("p0_busy",  32'(s_tready0), 32'd0);
            @(posedge aclk);
            #1;
        end
        s_tvalid0 = 1'b0;
        s_tlast0  = 1'b0;
        @(negedge aclk);
        check("p0_idle_ready", 32'(s_tready0), 32'd1);
        check("p0_idle_valid", 32'(m_tvalid0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
